// File: rtl/alu_exec_unit.sv
// RISC-V integer execute unit: base ALU ops in one pass plus iterative M-extension
// multiply (shift-add) and divide (restoring), one bit per cycle. XLEN is 32 or 64.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opb5,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BASIC = 3'd1,
    MUL   = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [XLEN-1:0]   a_r, b_r, magb_r, result_r, res_s;
  logic [1:0]        aluop_r;
  logic [2:0]        f3_r;
  logic              f7b5_r, opb5_r;
  logic              qneg_r, rneg_r, dz_r, ovf_r;
  logic [2*XLEN-1:0] work_r, work_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              busy_r, done_r, zero_r, load_res_s;

  logic              accept_s, mop_in_s, sa_s, sb_s;
  logic [XLEN-1:0]   basic_s, mulres_s, divres_s;
  logic [SHW-1:0]    shamt_s;
  logic [XLEN:0]     sum_s, shift_s;
  logic [XLEN-1:0]   diff_s, quo_s, rem_s;
  logic [2*XLEN-1:0] mstep_s, dstep_s, prod_s;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    if (sgn && v[XLEN-1]) mag = -v;
    else                  mag = v;
  endfunction

  assign accept_s = start && (state_r == IDLE);
  assign mop_in_s = (ALUOp == 2'b10) && opb5 && funct7b0;
  // operand signedness: mulh both, mulhsu only A, div/rem both, the rest unsigned
  assign sa_s = funct3[2] ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
  assign sb_s = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);

  // base ALU on the captured operands
  always_comb begin
    basic_s = {XLEN{1'b0}};
    shamt_s = b_r[SHW-1:0];
    case (aluop_r)
      2'b00: basic_s = a_r + b_r;
      2'b01: basic_s = a_r - b_r;
      2'b10: begin
        case (f3_r)
          3'b000: begin
            if (opb5_r && f7b5_r) basic_s = a_r - b_r;
            else                  basic_s = a_r + b_r;
          end
          3'b001: basic_s = a_r << shamt_s;
          3'b010: basic_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
          3'b011: basic_s = {{(XLEN-1){1'b0}}, (a_r < b_r)};
          3'b100: basic_s = a_r ^ b_r;
          3'b101: begin
            if (f7b5_r) basic_s = $signed(a_r) >>> shamt_s;
            else        basic_s = a_r >> shamt_s;
          end
          3'b110: basic_s = a_r | b_r;
          3'b111: basic_s = a_r & b_r;
          default: basic_s = {XLEN{1'b0}};
        endcase
      end
      default: basic_s = {XLEN{1'b0}};
    endcase
  end

  // multiply/divide step and final sign-corrected result selection
  always_comb begin
    sum_s   = {1'b0, work_r[2*XLEN-1:XLEN]} + (work_r[0] ? {1'b0, magb_r} : {(XLEN+1){1'b0}});
    mstep_s = {sum_s, work_r[XLEN-1:1]};
    prod_s  = qneg_r ? -work_r : work_r;
    if (f3_r[1:0] == 2'b00) mulres_s = prod_s[XLEN-1:0];
    else                    mulres_s = prod_s[2*XLEN-1:XLEN];

    shift_s = {work_r[2*XLEN-1:XLEN], work_r[XLEN-1]};
    diff_s  = shift_s[XLEN-1:0] - magb_r;
    if (shift_s >= {1'b0, magb_r}) dstep_s = {diff_s, work_r[XLEN-2:0], 1'b1};
    else                           dstep_s = {shift_s[XLEN-1:0], work_r[XLEN-2:0], 1'b0};

    quo_s = qneg_r ? -work_r[XLEN-1:0] : work_r[XLEN-1:0];
    rem_s = rneg_r ? -work_r[2*XLEN-1:XLEN] : work_r[2*XLEN-1:XLEN];
    if (dz_r)            divres_s = f3_r[1] ? a_r : {XLEN{1'b1}};
    else if (ovf_r)      divres_s = f3_r[1] ? {XLEN{1'b0}} : a_r;
    else if (f3_r[1])    divres_s = rem_s;
    else                 divres_s = quo_s;
  end

  // next-state and iteration control
  always_comb begin
    state_s    = state_r;
    work_s     = work_r;
    cnt_s      = cnt_r;
    res_s      = result_r;
    load_res_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (mop_in_s) state_s = funct3[2] ? DIV : MUL;
          else          state_s = BASIC;
          work_s = {{XLEN{1'b0}}, mag(srca, sa_s)};
          cnt_s  = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BASIC: begin
        state_s    = DONE;
        res_s      = basic_s;
        load_res_s = 1'b1;
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_s    = DONE;
          res_s      = mulres_s;
          load_res_s = 1'b1;
        end else begin
          work_s = mstep_s;
          cnt_s  = cnt_r + CNT_ONE;
        end
      end
      DIV: begin
        // divide-by-zero and signed overflow skip the iteration entirely
        if (dz_r || ovf_r || (cnt_r == CNT_LAST)) begin
          state_s    = DONE;
          res_s      = divres_s;
          load_res_s = 1'b1;
        end else begin
          work_s = dstep_s;
          cnt_s  = cnt_r + CNT_ONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, iteration and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      work_r   <= {(2*XLEN){1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
      zero_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == BASIC) || (state_s == MUL) || (state_s == DIV);
      done_r  <= (state_s == DONE);
      if (load_res_s) begin
        result_r <= res_s;
        zero_r   <= (res_s == {XLEN{1'b0}});
      end
    end
  end

  // operand and decode capture on an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      magb_r  <= {XLEN{1'b0}};
      aluop_r <= 2'b00;
      f3_r    <= 3'b000;
      f7b5_r  <= 1'b0;
      opb5_r  <= 1'b0;
      qneg_r  <= 1'b0;
      rneg_r  <= 1'b0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_r     <= srca;
      b_r     <= srcb;
      magb_r  <= mag(srcb, sb_s);
      aluop_r <= ALUOp;
      f3_r    <= funct3;
      f7b5_r  <= funct7b5;
      opb5_r  <= opb5;
      qneg_r  <= (sa_s && srca[XLEN-1]) ^ (sb_s && srcb[XLEN-1]);
      rneg_r  <= sa_s && srca[XLEN-1];
      dz_r    <= (srcb == {XLEN{1'b0}});
      ovf_r   <= funct3[2] && !funct3[0] && (srca == {1'b1, {(XLEN-1){1'b0}}})
                 && (srcb == {XLEN{1'b1}});
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign zero   = zero_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table on a 32-bit instance, hand-written
// sequences for start handling and reset abort, and a 64-bit multiply check.
module tb_alu_exec_unit;

  logic        clk, reset;
  logic        start, start64;
  logic [1:0]  aluop;
  logic [2:0]  f3;
  logic        f7b5, f7b0, opb5;
  logic [31:0] srca, srcb, result;
  logic [63:0] srca64, srcb64, result64;
  logic        busy, done, zero, busy64, done64, zero64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7b5, f7b0, opb5;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(aluop), .funct3(f3),
    .funct7b5(f7b5), .funct7b0(f7b0), .opb5(opb5), .srca(srca), .srcb(srcb),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  alu_exec_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .ALUOp(aluop), .funct3(f3),
    .funct7b5(f7b5), .funct7b0(f7b0), .opb5(opb5), .srca(srca64), .srcb(srcb64),
    .busy(busy64), .done(done64), .result(result64), .zero(zero64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] al, input logic [2:0] fn3, input logic b5,
                              input logic b0, input logic op5, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input int l);
    vec_t v;
    v.aluop = al; v.f3 = fn3; v.f7b5 = b5; v.f7b0 = b0; v.opb5 = op5;
    v.a = a; v.b = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // launch one op on the 32-bit unit, scramble inputs after acceptance, time the done pulse
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic seen;
    @(negedge clk);
    aluop = v.aluop; f3 = v.f3; f7b5 = v.f7b5; f7b0 = v.f7b0; opb5 = v.opb5;
    srca = v.a; srcb = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srca = $urandom; srcb = $urandom; aluop = 2'($urandom_range(3, 0));
    f3 = 3'($urandom_range(7, 0)); f7b5 = 1'($urandom_range(1, 0)); opb5 = 1'b1; f7b0 = 1'b1;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 200) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d result", idx), {32'h0, result}, {32'h0, v.exp});
    chk($sformatf("v%0d zero", idx), {63'h0, zero}, {63'h0, (v.exp == 32'h0)});
  endtask

  task automatic run64(input logic [2:0] fn3, input logic [63:0] exp);
    int lat;
    logic seen;
    @(negedge clk);
    aluop = 2'b10; f3 = fn3; f7b5 = 1'b0; f7b0 = 1'b1; opb5 = 1'b1;
    srca64 = {64{1'b1}}; srcb64 = {64{1'b1}}; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0; srca64 = 64'h0; srcb64 = 64'h0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 300) begin
      if (done64) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("x64 f3=%0d latency", fn3), 64'(lat), 64'd66);
    chk($sformatf("x64 f3=%0d result", fn3), result64, exp);
  endtask

  initial begin
    logic nodone;
    start = 1'b0; start64 = 1'b0; aluop = 2'b00; f3 = 3'b000;
    f7b5 = 1'b0; f7b0 = 1'b0; opb5 = 1'b0;
    srca = 32'h0; srcb = 32'h0; srca64 = 64'h0; srcb64 = 64'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'h0, busy}, 64'h0);
    chk("reset done", {63'h0, done}, 64'h0);
    chk("reset result", {32'h0, result}, 64'h0);
    chk("reset zero", {63'h0, zero}, 64'h1);
    reset = 1'b0;

    //                 ALUOp  f3     b5    b0    op5   a             b             expected      lat
    vecs.push_back(mk(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        32'd12,       2));
    vecs.push_back(mk(2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 2));
    vecs.push_back(mk(2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        32'h0,        2));
    vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 2));
    vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       2));
    vecs.push_back(mk(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h0,        2));
    vecs.push_back(mk(2'b00, 3'b000, 1'b0, 1'b1, 1'b1, 32'd5,        32'd7,        32'd12,       2));
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 32'd5,        32'd7,        32'd2,        2));
    vecs.push_back(mk(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1,        32'd36,       32'h10,       2));
    vecs.push_back(mk(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd1,        2));
    vecs.push_back(mk(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        2));
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 2));
    vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 2));
    vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 2));
    vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0000000, 32'h0000000F, 32'hF000000F, 2));
    vecs.push_back(mk(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 2));
    vecs.push_back(mk(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        34));
    vecs.push_back(mk(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34));
    vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        34));
    vecs.push_back(mk(2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34));
    vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34));
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34));
    vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34));
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34));
    vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        34));
    vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100,      32'd7,        32'd14,       34));
    vecs.push_back(mk(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100,      32'd7,        32'd2,        34));
    vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 2));
    vecs.push_back(mk(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd5,        32'd0,        32'd5,        2));
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 2));
    vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2));
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2));
    vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        2));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // start held high through done: ignored in DONE, accepted again once back in IDLE
    @(negedge clk);
    aluop = 2'b00; f3 = 3'b000; f7b0 = 1'b0; opb5 = 1'b1; srca = 32'd5; srcb = 32'd7; start = 1'b1;
    @(negedge clk);
    chk("hold c1 busy", {63'h0, busy}, 64'h1);
    chk("hold c1 done", {63'h0, done}, 64'h0);
    @(negedge clk);
    chk("hold c2 done", {63'h0, done}, 64'h1);
    chk("hold c2 result", {32'h0, result}, 64'd12);
    srca = 32'd1; srcb = 32'd1;
    @(negedge clk);
    chk("hold c3 busy", {63'h0, busy}, 64'h0);
    chk("hold c3 done", {63'h0, done}, 64'h0);
    @(negedge clk);
    chk("hold c4 busy", {63'h0, busy}, 64'h1);
    start = 1'b0;
    @(negedge clk);
    chk("hold c5 done", {63'h0, done}, 64'h1);
    chk("hold c5 result", {32'h0, result}, 64'd2);

    // mul in flight, second start at cycle 5, reset at cycle 10 aborts with no done
    @(negedge clk);
    aluop = 2'b10; f3 = 3'b011; f7b0 = 1'b1; opb5 = 1'b1;
    srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nodone = 1'b1;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        aluop = 2'b00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) nodone = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("abort pre busy", {63'h0, busy}, 64'h1);
    chk("abort no early done", {63'h0, nodone}, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", {63'h0, busy}, 64'h0);
    chk("abort done", {63'h0, done}, 64'h0);
    chk("abort result", {32'h0, result}, 64'h0);
    chk("abort zero", {63'h0, zero}, 64'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nodone = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (done) nodone = 1'b0;
      @(negedge clk);
    end
    chk("abort no done", {63'h0, nodone}, 64'h1);

    run64(3'b011, 64'hFFFFFFFFFFFFFFFE);
    run64(3'b001, 64'h0);
    run64(3'b000, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
